pc_sequencer: RTL and testbench

Parametrised program-counter sequencer: the next-generation instruction-fetch frontend of the simple CPU. It keeps the fetch address and computes the next address from the current opcode, immediate and condition flag. It adds to the base design a hardware return-address stack (CALL/RET), an inverted branch, a fetch-stall handshake, a resumable halt, and a fault state for stack misuse. It sits between instruction decode and instruction memory; `pc_out` drives the fetch address.

---
 rtl/pc_seq_pkg.sv | 18 +
 rtl/ras_stack.sv | 52 +++++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared opcode encodings and sequencer state type for the fetch frontend.
package pc_seq_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_JMP  = 8'h01;
  localparam logic [7:0] OP_BREQ = 8'h02;
  localparam logic [7:0] OP_BRNE = 8'h03;
  localparam logic [7:0] OP_CALL = 8'h04;
  localparam logic [7:0] OP_RET  = 8'h05;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

endpackage

// File: rtl/ras_stack.sv
// Return-address LIFO. A push when full or a pop when empty is dropped here;
// the sequencer decides what misuse means architecturally.
module ras_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] top,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
  logic [ADDR_W-1:0] mem_d [STACK_DEPTH];

  assign full  = (level_q == LVL_W'(STACK_DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

  always_comb begin
    level_d = level_q;
    mem_d   = mem_q;
    top     = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && !full && (level_q == LVL_W'(i))) mem_d[i] = wdata;
      if (level_q == LVL_W'(i + 1)) top = mem_q[i];
    end
    if (push && !full) begin
      level_d = level_q + 1'b1;
    end else if (pop && !empty) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) level_q <= '0;
    else     level_q <= level_d;
  end

  // Entry contents carry no reset; level alone defines what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: PC register, RUN/HALT/FAULT control and the
// next-PC mux, with a hardware return-address stack for CALL/RET.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8,
  parameter int RESET_PC    = 0,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [7:0]        opcode,
  input  logic [ADDR_W-1:0] imm,
  input  logic              condition,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              fault,
  output logic [LVL_W-1:0]  stack_level
);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc, pc_rel;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  logic              stk_full, stk_empty;

  ras_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (pc_inc),
    .top   (stk_top),
    .level (stack_level),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + imm;

  // instr_valid qualifies opcode/imm/condition with no ready return path:
  // low means the frontend stalls and the PC holds.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      RUN: begin
        if (instr_valid) begin
          case (opcode)
            OP_JMP:  pc_d = imm;
            OP_BREQ: pc_d = condition ? pc_rel : pc_inc;
            OP_BRNE: pc_d = condition ? pc_inc : pc_rel;
            OP_CALL: begin
              if (stk_full) begin
                state_d = FAULT;
              end else begin
                push = 1'b1;
                pc_d = imm;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_d = FAULT;
              end else begin
                pop  = 1'b1;
                pc_d = stk_top;
              end
            end
            OP_HALT: state_d = HALT;
            default: pc_d = pc_inc;
          endcase
        end
      end
      HALT: begin
        if (resume) begin
          state_d = RUN;
          pc_d    = pc_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= ADDR_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc_out = pc_q;
  assign halted = (state_q == HALT);
  assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a 16-bit/depth-2 instance for control and
// stack behaviour, and a 4-bit/depth-8 instance for address wrap.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance: ADDR_W=16, STACK_DEPTH=2
  logic        rst = 1'b1, instr_valid = 1'b0, condition = 1'b0, resume = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [15:0] imm = '0;
  logic [15:0] pc_out;
  logic        halted, fault;
  logic [1:0]  stack_level;

  // narrow instance: ADDR_W=4, STACK_DEPTH=8
  logic        w4_rst = 1'b1, w4_valid = 1'b0, w4_cond = 1'b0, w4_resume = 1'b0;
  logic [7:0]  w4_op = 8'h00;
  logic [3:0]  w4_imm = '0;
  logic [3:0]  w4_pc;
  logic        w4_halted, w4_fault;
  logic [3:0]  w4_level;

  pc_sequencer #(.ADDR_W(16), .STACK_DEPTH(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode),
    .imm(imm), .condition(condition), .resume(resume), .pc_out(pc_out),
    .halted(halted), .fault(fault), .stack_level(stack_level)
  );

  pc_sequencer #(.ADDR_W(4), .STACK_DEPTH(8), .RESET_PC(0)) dut_w4 (
    .clk(clk), .rst(w4_rst), .instr_valid(w4_valid), .opcode(w4_op),
    .imm(w4_imm), .condition(w4_cond), .resume(w4_resume), .pc_out(w4_pc),
    .halted(w4_halted), .fault(w4_fault), .stack_level(w4_level)
  );

  // ---------------- scoreboard ----------------
  // entry = {sel, pc[15:0], halted, fault, level[3:0]}
  localparam int W = 23;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (e[W-1] == 1'b0) a = {1'b0, pc_out, halted, fault, 2'b00, stack_level};
      else                a = {1'b1, 12'h000, w4_pc, w4_halted, w4_fault, w4_level};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got pc=%h halted=%b fault=%b level=%0d, expected pc=%h halted=%b fault=%b level=%0d",
                 t, a[21:6], a[5], a[4], a[3:0], e[21:6], e[5], e[4], e[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sel, input logic r, input logic v,
                       input logic [7:0] op, input logic [15:0] im,
                       input logic c, input logic res,
                       input logic [15:0] epc, input logic eh, input logic ef,
                       input logic [3:0] elv, input string tag);
    if (!sel) begin
      rst = r; instr_valid = v; opcode = op; imm = im; condition = c; resume = res;
      w4_rst = 1'b0; w4_valid = 1'b0; w4_resume = 1'b0;
    end else begin
      w4_rst = r; w4_valid = v; w4_op = op; w4_imm = im[3:0]; w4_cond = c; w4_resume = res;
      rst = 1'b0; instr_valid = 1'b0; resume = 1'b0;
    end
    exp_q.push_back({sel, epc, eh, ef, elv});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // main instance, valid instruction, RUN expected
  task automatic m_op(input logic [7:0] op, input logic [15:0] im, input logic c,
                      input logic [15:0] epc, input logic [3:0] elv, input string tag);
    drive(1'b0, 1'b0, 1'b1, op, im, c, 1'b0, epc, 1'b0, 1'b0, elv, tag);
  endtask

  task automatic m_rst(input string tag);
    drive(1'b0, 1'b1, 1'b0, OP_NOP, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0, tag);
  endtask

  task automatic w_op(input logic [7:0] op, input logic [15:0] im,
                      input logic [15:0] epc, input logic [3:0] elv, input string tag);
    drive(1'b1, 1'b0, 1'b1, op, im, 1'b0, 1'b0, epc, 1'b0, 1'b0, elv, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset and sequential run
    m_rst("reset");
    m_op(OP_NOP, 16'h0, 1'b0, 16'd1, 4'd0, "nop_1");
    m_op(OP_NOP, 16'h0, 1'b0, 16'd2, 4'd0, "nop_2");
    m_op(OP_NOP, 16'h0, 1'b0, 16'd3, 4'd0, "nop_3");
    for (int i = 0; i < 2; i++)
      drive(1'b0, 1'b0, 1'b0, OP_JMP, 16'd99, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0, 4'd0, "stall");

    // branches
    m_op(OP_JMP,  16'd10,   1'b0, 16'd10, 4'd0, "jmp_10");
    m_op(OP_BREQ, 16'hFFFC, 1'b1, 16'd6,  4'd0, "breq_taken_neg");
    m_op(OP_BRNE, 16'd5,    1'b1, 16'd7,  4'd0, "brne_not_taken");
    m_op(OP_BRNE, 16'd5,    1'b0, 16'd12, 4'd0, "brne_taken");
    m_op(OP_BREQ, 16'd5,    1'b0, 16'd13, 4'd0, "breq_not_taken");

    // nested call/ret
    m_op(OP_JMP,  16'd4,   1'b0, 16'd4,   4'd0, "jmp_4");
    m_op(OP_CALL, 16'd100, 1'b0, 16'd100, 4'd1, "call_100");
    m_op(OP_CALL, 16'd200, 1'b0, 16'd200, 4'd2, "call_200");
    m_op(OP_RET,  16'd0,   1'b0, 16'd101, 4'd1, "ret_101");
    m_op(OP_RET,  16'd0,   1'b0, 16'd5,   4'd0, "ret_5");
    m_op(8'h42,   16'd77,  1'b1, 16'd6,   4'd0, "undef_as_nop");

    // halt and resume
    m_op(OP_JMP,  16'd7, 1'b0, 16'd7, 4'd0, "jmp_7");
    drive(1'b0, 1'b0, 1'b1, OP_HALT, 16'd0, 1'b0, 1'b0, 16'd7, 1'b1, 1'b0, 4'd0, "halt_enter");
    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b0, 1'b1, OP_JMP, 16'd50, 1'b0, 1'b0, 16'd7, 1'b1, 1'b0, 4'd0, "halt_hold");
    drive(1'b0, 1'b0, 1'b1, OP_JMP, 16'd50, 1'b0, 1'b1, 16'd8, 1'b0, 1'b0, 4'd0, "resume");
    m_op(OP_CALL, 16'd300, 1'b0, 16'd300, 4'd1, "call_300");
    drive(1'b0, 1'b0, 1'b1, OP_HALT, 16'd0, 1'b0, 1'b0, 16'd300, 1'b1, 1'b0, 4'd1, "halt_keeps_stack");
    drive(1'b0, 1'b0, 1'b0, OP_NOP, 16'd0, 1'b0, 1'b1, 16'd301, 1'b0, 1'b0, 4'd1, "resume_keeps_stack");
    m_op(OP_RET,  16'd0, 1'b0, 16'd9, 4'd0, "ret_after_halt");

    // 16-bit wrap
    m_op(OP_JMP,  16'hFFFF, 1'b0, 16'hFFFF, 4'd0, "jmp_ffff");
    m_op(OP_NOP,  16'h0,    1'b0, 16'h0000, 4'd0, "wrap_inc");
    m_op(OP_BRNE, 16'hFFFF, 1'b0, 16'hFFFF, 4'd0, "wrap_minus1");

    // overflow fault
    m_op(OP_JMP,  16'd20, 1'b0, 16'd20, 4'd0, "jmp_20");
    m_op(OP_CALL, 16'd30, 1'b0, 16'd30, 4'd1, "ovf_call1");
    m_op(OP_CALL, 16'd40, 1'b0, 16'd40, 4'd2, "ovf_call2");
    drive(1'b0, 1'b0, 1'b1, OP_CALL, 16'd50, 1'b0, 1'b0, 16'd40, 1'b0, 1'b1, 4'd2, "ovf_fault");
    drive(1'b0, 1'b0, 1'b0, OP_NOP,  16'd0,  1'b0, 1'b1, 16'd40, 1'b0, 1'b1, 4'd2, "fault_resume_ign");
    drive(1'b0, 1'b0, 1'b1, OP_RET,  16'd0,  1'b0, 1'b0, 16'd40, 1'b0, 1'b1, 4'd2, "fault_frozen_ret");
    drive(1'b0, 1'b0, 1'b1, OP_HALT, 16'd0,  1'b0, 1'b0, 16'd40, 1'b0, 1'b1, 4'd2, "fault_frozen_halt");
    m_rst("reset_clears_fault");

    // underflow fault
    drive(1'b0, 1'b0, 1'b1, OP_RET, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd0, "udf_fault");
    m_rst("reset_after_udf");

    // reset in the same cycle as a CALL empties the stack
    m_op(OP_NOP, 16'd0, 1'b0, 16'd1, 4'd0, "pre_call_nop");
    drive(1'b0, 1'b1, 1'b1, OP_CALL, 16'd77, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, "rst_mid_call");
    drive(1'b0, 1'b0, 1'b1, OP_RET, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd0, "stack_empty_after_rst");

    // reset out of HALT
    m_rst("reset_pre_halt");
    drive(1'b0, 1'b0, 1'b1, OP_HALT, 16'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 4'd0, "halt_at_0");
    m_rst("reset_clears_halt");

    // 4-bit instance: wrap and pushed-value wrap
    drive(1'b1, 1'b1, 1'b0, OP_NOP, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, "w4_reset");
    w_op(OP_JMP,  16'd15, 16'd15, 4'd0, "w4_jmp_15");
    w_op(OP_NOP,  16'd0,  16'd0,  4'd0, "w4_wrap");
    w_op(OP_CALL, 16'd15, 16'd15, 4'd1, "w4_call_15");
    w_op(OP_RET,  16'd0,  16'd1,  4'd0, "w4_ret_1");
    w_op(OP_JMP,  16'd15, 16'd15, 4'd0, "w4_jmp_15b");
    w_op(OP_CALL, 16'd3,  16'd3,  4'd1, "w4_call_from_15");
    w_op(OP_RET,  16'd0,  16'd0,  4'd0, "w4_ret_wrapped");

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
